// File: rtl/qspi_ram_responder.sv
// Quad-SPI memory target: decodes write (0x02) and fast-read (0x0B) commands from the
// controller and serves them from an internal byte array, with SCK oversampled on clk.
module qspi_ram_responder #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk,
  input  logic                 spi_cs_n,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic                 txn_active,
  output logic                 cmd_error
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } state_t;

  state_t               state, state_n;
  logic                 sck_q;
  logic                 rise, fall;
  logic [2:0]           cnt;
  logic                 nib_lo;
  logic [3:0]           cmd_hi;
  logic [7:0]           cmd_byte;
  logic                 cmd_ok;
  logic                 is_write;
  logic [ADDR_BITS-1:0] addr;
  logic [3:0]           wr_hi;
  logic [7:0]           rd_byte;
  logic                 bus_we;
  logic [7:0]           mem [2**ADDR_BITS];

  // CS high masks both edges, so a CS rise coinciding with an SCK edge wins
  assign rise     = !spi_cs_n && !sck_q && spi_clk;
  assign fall     = !spi_cs_n && sck_q && !spi_clk;
  assign cmd_byte = {cmd_hi, spi_data_in};
  assign cmd_ok   = (cmd_byte == 8'h02) || (cmd_byte == 8'h0B);
  assign bus_we   = (state == WDATA) && rise && nib_lo;

  assign spi_data_oe = (state == RDATA) ? 4'hF : 4'h0;

  always_comb begin
    state_n = state;
    if (spi_cs_n) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, CMD: begin
          state_n = CMD;
          if (rise && cnt == 3'd1) state_n = cmd_ok ? ADDR : IGNORE;
        end
        ADDR:    if (rise && cnt == 3'd5) state_n = is_write ? WDATA : DUMMY;
        DUMMY:   if (fall && cnt == 3'd4) state_n = RDATA;
        default: state_n = state;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      sck_q        <= 1'b0;
      cnt          <= 3'd0;
      nib_lo       <= 1'b0;
      txn_active   <= 1'b0;
      cmd_error    <= 1'b0;
      spi_data_out <= 4'h0;
    end else begin
      state <= state_n;
      sck_q <= spi_clk;
      if (spi_cs_n) begin
        cnt        <= 3'd0;
        nib_lo     <= 1'b0;
        txn_active <= 1'b0;
      end else begin
        if (rise) txn_active <= 1'b1;
        case (state)
          IDLE, CMD: if (rise) begin
            cnt <= (cnt == 3'd0) ? 3'd1 : 3'd0;
            if (cnt == 3'd1 && !cmd_ok) cmd_error <= 1'b1;
          end
          ADDR: if (rise) cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
          DUMMY: begin
            if (rise && cnt != 3'd4) cnt <= cnt + 3'd1;
            if (fall && cnt == 3'd4) begin
              spi_data_out <= rd_byte[7:4];
              nib_lo       <= 1'b1;
              cnt          <= 3'd0;
            end
          end
          RDATA: if (fall) begin
            spi_data_out <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
            nib_lo       <= !nib_lo;
          end
          WDATA: if (rise) nib_lo <= !nib_lo;
          default: ;
        endcase
      end
    end
  end

  // Datapath: address, command capture and the byte array (never reset)
  always_ff @(posedge clk) begin
    if ((state == IDLE || state == CMD) && rise && cnt == 3'd0) cmd_hi <= spi_data_in;
    if ((state == IDLE || state == CMD) && rise && cnt == 3'd1) is_write <= (cmd_byte == 8'h02);
    if (state == ADDR && rise) addr <= {addr[ADDR_BITS-5:0], spi_data_in};
    if (state == WDATA && rise && !nib_lo) wr_hi <= spi_data_in;
    if ((state == RDATA && fall && nib_lo) || bus_we) addr <= addr + 1'b1;
    // A bus write to the same byte as the backdoor lands last and wins
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (bus_we) mem[addr] <= {wr_hi, spi_data_in};
    // Registered read tracks addr; it settles well before the next SCK fall
    rd_byte <= mem[addr];
  end

endmodule

// File: doc/qspi_ram_responder.md
# qspi_ram_responder

Synthesizable QSPI memory responder: the target end of the quad-SPI bus driven by the TinyQV memory/QSPI controller. It decodes command, address and data nibbles from the bus and serves reads and writes from an internal byte array. It plugs into the RAM A or RAM B select line in FPGA builds and self-checking benches. SCK and data are sampled in the `clk` domain, so SCK must be generated synchronously from `clk`.

## Interface
- `ADDR_BITS`, 12, byte-address width of the internal array (2^ADDR_BITS bytes).
- `clk`  in  1  system clock; SCK is oversampled on it.
- `rstn`  in  1  reset, synchronous, active-low.
- `spi_clk`  in  1  bus SCK; idles low.
- `spi_cs_n`  in  1  chip select, active-low.
- `spi_data_in`  in  4  bus data as driven by the controller.
- `spi_data_out`  out  4  read data nibble.
- `spi_data_oe`  out  4  output enable, 4'hF while driving, else 4'h0.
- `bd_we`  in  1  backdoor byte write strobe, for test preload.
- `bd_addr`  in  ADDR_BITS  backdoor address.
- `bd_wdata`  in  8  backdoor data.
- `txn_active`  out  1  high from the first command nibble until CS rises.
- `cmd_error`  out  1  sticky: an unsupported command was seen; cleared only by reset.

## Operation
- Edge detection uses the registered SCK value `sck_q`.
  - Rise: `sck_q`=0 and `spi_clk`=1.
  - Fall: `sck_q`=1 and `spi_clk`=0.
  - All bus activity is ignored while `spi_cs_n`=1.
- All fields are quad and MSB-nibble first:
  - command: 2 nibbles;
  - address: 6 nibbles (24 bits), of which the low ADDR_BITS are used and upper bits are ignored.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD when CS falls.
  - CMD: on the 2nd rise, go to ADDR if the command is 0x02 (write) or 0x0B (read). Otherwise go to IGNORE and set `cmd_error`.
  - ADDR: after the 6th rise, 0x02 → WDATA and 0x0B → DUMMY.
  - DUMMY: counts 4 rises. On the fall that follows the 4th rise, go to RDATA and drive the high nibble of mem[addr].
  - RDATA: each subsequent fall drives the next nibble. After a low nibble, addr increments and the high nibble of the new byte is driven.
  - WDATA: rises alternate high/low nibble. On the low-nibble rise, write mem[addr] <= {hi, lo} and increment addr.
  - IGNORE: holds until CS rises.
- Any state → IDLE on CS high. A partial byte is discarded and never written.
- Address increments wrap modulo 2^ADDR_BITS.
- Stall: the controller may hold SCK in either level for any number of cycles. All state, addr and `spi_data_out` hold meanwhile.
- `bd_we` writes mem[bd_addr] in any state. If it hits the same cycle and address as a bus write, the bus write wins.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - `spi_data_out` = 0, `spi_data_oe` = 0, `txn_active` = 0, `cmd_error` = 0;
  - state = IDLE, `sck_q` = 0.
- `spi_data_oe` = 4'hF from the registered output cycle following the DUMMY→RDATA fall until the cycle after CS rises; it is 4'h0 in every other state.
- Sampling: `spi_data_in` is captured on the `clk` edge at which the rise is detected.
- Output timing: `spi_data_out` changes on the `clk` edge after the fall is detected (1-cycle latency). The controller samples on the next SCK rise.
- SCK constraints: high and low phases each ≥2 `clk` periods.
- Read data comes from a registered array read issued on the low-nibble fall (or the DUMMY→RDATA fall). It is valid before the next fall.
- Simultaneous events:
  - CS rise on the same cycle as an SCK edge: CS wins and the edge is ignored.
  - `rstn`=0 has priority over everything. Mid-transaction it forces IDLE and `spi_data_oe` = 0 on the next clock.

## Test plan
- Write then read back: send write 0x02, addr 0x000010, data 0xA5 0x3C. Then send read 0x0B, addr 0x000010, 4 dummy clocks, read 2 bytes → nibbles A,5,3,C.
- Wrap: write at addr 0x000FFF with bytes 0x11 0x22 (ADDR_BITS=12) → backdoor-checked mem[0xFFF]=0x11, mem[0x000]=0x22. Reading from 0xFFF returns 11 22.
- Stall: during a read, hold SCK low for 20 clk after the 1st data nibble → `spi_data_out` stable for all 20 cycles, and the subsequent nibbles are correct and contiguous.
- Bad command: send 0x9F plus 8 clocks → `cmd_error`=1, `spi_data_oe` stays 0, memory unchanged.
- Aborted write: CS rises after a single data nibble → target byte unchanged, and the next transaction decodes normally.
- Reset mid-read: assert `rstn`=0 during RDATA → `spi_data_oe`=0 and `txn_active`=0 on the next clk. Memory preloaded via backdoor (mem[0x20]=0x5A) is still read back as 5A afterwards.
